// File: rtl/karat_mult_driver.sv
// karat_mult_driver: handshake front-end for a multi-cycle multiplier.
// Accepts an operand pair on a valid/ready handshake, holds it on the
// multiplier operand bus while the enable is high, waits for the finish pulse
// (bounded by TIMEOUT), then presents the product downstream until accepted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_valid, o_ready    upstream handshake (o_ready high only when idle)
//   iA, iB              upstream operands
//   o_valid, i_ready    downstream handshake (o_valid high only while holding)
//   oP                  captured product
//   o_mult_enable       multiplier enable, high for the whole busy phase
//   o_mult_x, o_mult_y  operands presented to the multiplier
//   i_mult_finish       multiplier finish pulse
//   i_mult_o            multiplier product
//   o_timeout           sticky flag: an operation was abandoned on timeout
//   o_count             completed downstream transfers (wrapping)
//   o_last_lat          enable-to-finish latency of the last finished op
module karat_mult_driver #(
  parameter int unsigned wI      = 1024,
  parameter int unsigned wO      = 2 * wI,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [wI-1:0] iA,
  input  logic [wI-1:0] iB,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [wO-1:0] oP,
  output logic          o_mult_enable,
  output logic [wI-1:0] o_mult_x,
  output logic [wI-1:0] o_mult_y,
  input  logic          i_mult_finish,
  input  logic [wO-1:0] i_mult_o,
  output logic          o_timeout,
  output logic [15:0]   o_count,
  output logic [15:0]   o_last_lat
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] lat_cnt, lat_cnt_d;
  logic [wI-1:0]    x_d, y_d;
  logic [wO-1:0]    p_d;
  logic [CNT_W-1:0] last_lat_d, count_d;
  logic             timeout_d;

  // Next-state and next-value logic
  always_comb begin
    state_d    = state;
    lat_cnt_d  = lat_cnt;
    x_d        = o_mult_x;
    y_d        = o_mult_y;
    p_d        = oP;
    last_lat_d = o_last_lat;
    count_d    = o_count;
    timeout_d  = o_timeout;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          x_d       = iA;
          y_d       = iB;
          lat_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // Finish takes priority over a coincident timeout.
        if (i_mult_finish) begin
          p_d        = i_mult_o;
          last_lat_d = (lat_cnt == CNT_MAX) ? CNT_MAX : lat_cnt + CNT_W'(1);
          state_d    = HOLD;
        end else if (lat_cnt == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (lat_cnt != CNT_MAX) begin
          lat_cnt_d = lat_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (i_ready) begin
          count_d = o_count + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; handshake flags decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      o_mult_x      <= '0;
      o_mult_y      <= '0;
      oP            <= '0;
      o_last_lat    <= '0;
      o_count       <= '0;
      o_timeout     <= 1'b0;
      o_ready       <= 1'b1;
      o_valid       <= 1'b0;
      o_mult_enable <= 1'b0;
    end else begin
      state         <= state_d;
      lat_cnt       <= lat_cnt_d;
      o_mult_x      <= x_d;
      o_mult_y      <= y_d;
      oP            <= p_d;
      o_last_lat    <= last_lat_d;
      o_count       <= count_d;
      o_timeout     <= timeout_d;
      o_ready       <= (state_d == IDLE);
      o_valid       <= (state_d == HOLD);
      o_mult_enable <= (state_d == BUSY);
    end
  end

endmodule

// File: tb/tb_karat_mult_driver.sv
// Self-checking bench for karat_mult_driver: a wide instance with a modelled
// multiplier of configurable latency, and a narrow TIMEOUT=16 instance whose
// finish input is driven directly.
module tb_karat_mult_driver;

  localparam int WI = 1024;
  localparam int WO = 2 * WI;
  localparam int TI = 8;
  localparam int TO = 16;

  logic clk;
  logic rst;

  // Main instance signals
  logic          d_valid, d_ready_o, d_valid_o, d_ready, d_en, d_finish, d_timeout;
  logic [WI-1:0] d_a, d_b, d_x, d_y;
  logic [WO-1:0] d_p, d_mult_o;
  logic [15:0]   d_count, d_last_lat;

  // Timeout instance signals
  logic          t_valid, t_ready_o, t_valid_o, t_ready, t_en, t_finish, t_timeout;
  logic [TI-1:0] t_a, t_b, t_x, t_y;
  logic [TO-1:0] t_p, t_mult_o;
  logic [15:0]   t_count, t_last_lat;

  // Multiplier model controls
  int            mult_lat;
  int            en_cnt;
  logic          inject_finish;
  logic [WO-1:0] inject_val;

  int errors;
  int checks;
  int cyc;
  logic [WO-1:0] exp_q[$];

  karat_mult_driver u_dut (
    .clk(clk), .rst(rst),
    .i_valid(d_valid), .o_ready(d_ready_o), .iA(d_a), .iB(d_b),
    .o_valid(d_valid_o), .i_ready(d_ready), .oP(d_p),
    .o_mult_enable(d_en), .o_mult_x(d_x), .o_mult_y(d_y),
    .i_mult_finish(d_finish), .i_mult_o(d_mult_o),
    .o_timeout(d_timeout), .o_count(d_count), .o_last_lat(d_last_lat)
  );

  karat_mult_driver #(.wI(TI), .wO(TO), .TIMEOUT(16)) u_to (
    .clk(clk), .rst(rst),
    .i_valid(t_valid), .o_ready(t_ready_o), .iA(t_a), .iB(t_b),
    .o_valid(t_valid_o), .i_ready(t_ready), .oP(t_p),
    .o_mult_enable(t_en), .o_mult_x(t_x), .o_mult_y(t_y),
    .i_mult_finish(t_finish), .i_mult_o(t_mult_o),
    .o_timeout(t_timeout), .o_count(t_count), .o_last_lat(t_last_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: finish during the mult_lat-th enabled cycle
  always @(posedge clk) begin
    if (d_en) en_cnt <= en_cnt + 1;
    else      en_cnt <= 0;
  end
  assign d_finish = inject_finish | (d_en && (en_cnt == mult_lat - 1));
  assign d_mult_o = inject_finish ? inject_val : (WO'(d_x) * WO'(d_y));
  assign t_mult_o = 16'hBEEF;

  function automatic logic [WI-1:0] rand_wide();
    logic [WI-1:0] r;
    for (int i = 0; i < WI / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    d_valid = 1'b0;
    t_valid = 1'b0;
    t_finish = 1'b0;
    inject_finish = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Drive one pair on the main instance (caller ensures o_ready) and push expectation
  task automatic issue(input logic [WI-1:0] a, input logic [WI-1:0] b);
    d_a = a;
    d_b = b;
    d_valid = 1'b1;
    exp_q.push_back(WO'(a) * WO'(b));
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (d_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (d_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", d_ready_o); end
    checks++; if (d_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", d_valid_o); end
    checks++; if (d_en !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", d_en); end
    checks++; if (d_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", d_timeout); end
    checks++; if (d_p !== '0) begin errors++; $display("FAIL reset_oP: low64 got %h want 0", d_p[63:0]); end
    checks++; if (d_x !== '0 || d_y !== '0) begin errors++; $display("FAIL reset_xy: low32 x=%h y=%h want 0", d_x[31:0], d_y[31:0]); end
    checks++; if (d_count !== 16'd0 || d_last_lat !== 16'd0) begin errors++; $display("FAIL reset_counters: count=%0d lat=%0d want 0", d_count, d_last_lat); end
    checks++; if (t_ready_o !== 1'b1 || t_timeout !== 1'b0) begin errors++; $display("FAIL reset_to_inst: ready=%b timeout=%b want 1/0", t_ready_o, t_timeout); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [WO-1:0] e;
    do_reset();
    mult_lat = 4;
    d_ready = 1'b1;
    issue(WI'(3), WI'(5));
    checks++; if (d_en !== 1'b1 || d_ready_o !== 1'b0 || d_x !== WI'(3) || d_y !== WI'(5)) begin
      errors++; $display("FAIL basic_busy: en=%b ready=%b x=%0d y=%0d want 1/0/3/5", d_en, d_ready_o, d_x[31:0], d_y[31:0]);
    end
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_valid_timeout: o_valid never rose"); end
    e = exp_q.pop_front();
    checks++; if (d_p !== e || d_p !== WO'(15)) begin errors++; $display("FAIL basic_oP: got %0d want 15", d_p[63:0]); end
    checks++; if (d_last_lat !== 16'd4) begin errors++; $display("FAIL basic_last_lat: got %0d want 4", d_last_lat); end
    @(negedge clk);
    checks++; if (d_valid_o !== 1'b0 || d_ready_o !== 1'b1) begin errors++; $display("FAIL basic_one_cycle: valid=%b ready=%b want 0/1", d_valid_o, d_ready_o); end
    checks++; if (d_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", d_count); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [WO-1:0] e;
    do_reset();
    mult_lat = 4;
    d_ready = 1'b0;
    issue(WI'(3), WI'(5));
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_valid_timeout: o_valid never rose"); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (d_valid_o !== 1'b1 || d_p !== WO'(15) || d_ready_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: valid=%b oP=%0d ready=%b want 1/15/0", i, d_valid_o, d_p[63:0], d_ready_o);
      end
      @(negedge clk);
    end
    // Finish pulse while holding must not disturb the product
    inject_val = '1;
    inject_finish = 1'b1;
    @(negedge clk);
    inject_finish = 1'b0;
    checks++; if (d_p !== WO'(15) || d_valid_o !== 1'b1) begin errors++; $display("FAIL hold_finish_ignored: oP low64=%h valid=%b want 15/1", d_p[63:0], d_valid_o); end
    d_ready = 1'b1;
    e = exp_q.pop_front();
    checks++; if (d_p !== e) begin errors++; $display("FAIL stall_oP: got %0d want %0d", d_p[63:0], e[63:0]); end
    @(negedge clk);
    checks++; if (d_ready_o !== 1'b1 || d_valid_o !== 1'b0 || d_count !== 16'd1) begin
      errors++; $display("FAIL stall_release: ready=%b valid=%b count=%0d want 1/0/1", d_ready_o, d_valid_o, d_count);
    end
  endtask

  task automatic test_idle_finish();
    do_reset();
    inject_val = '1;
    inject_finish = 1'b1;
    @(negedge clk);
    inject_finish = 1'b0;
    @(negedge clk);
    checks++; if (d_p !== '0 || d_valid_o !== 1'b0 || d_ready_o !== 1'b1) begin
      errors++; $display("FAIL idle_finish: oP low64=%h valid=%b ready=%b want 0/0/1", d_p[63:0], d_valid_o, d_ready_o);
    end
    checks++; if (d_last_lat !== 16'd0) begin errors++; $display("FAIL idle_finish_lat: got %0d want 0", d_last_lat); end
  endtask

  task automatic test_finish_vs_timeout();
    do_reset();
    t_ready = 1'b0;
    t_a = 8'd11;
    t_b = 8'd13;
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    repeat (15) @(negedge clk);
    t_finish = 1'b1;
    @(negedge clk);
    t_finish = 1'b0;
    checks++; if (t_valid_o !== 1'b1 || t_timeout !== 1'b0) begin errors++; $display("FAIL race_state: valid=%b timeout=%b want 1/0", t_valid_o, t_timeout); end
    checks++; if (t_p !== 16'hBEEF || t_last_lat !== 16'd16) begin errors++; $display("FAIL race_capture: oP=%h lat=%0d want beef/16", t_p, t_last_lat); end
    t_ready = 1'b1;
    @(negedge clk);
    t_ready = 1'b0;
    checks++; if (t_count !== 16'd1 || t_ready_o !== 1'b1) begin errors++; $display("FAIL race_count: count=%0d ready=%b want 1/1", t_count, t_ready_o); end
  endtask

  task automatic test_timeout();
    int en_cycles;
    bit seen_valid;
    do_reset();
    t_ready = 1'b1;
    t_a = 8'd7;
    t_b = 8'd9;
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    en_cycles = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (t_en) en_cycles++;
      if (t_valid_o) seen_valid = 1'b1;
      @(negedge clk);
    end
    checks++; if (en_cycles != 16) begin errors++; $display("FAIL timeout_en_cycles: got %0d want 16", en_cycles); end
    checks++; if (t_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", t_timeout); end
    checks++; if (seen_valid || t_count !== 16'd0 || t_p !== 16'd0) begin
      errors++; $display("FAIL timeout_discard: seen_valid=%b count=%0d oP=%h want 0/0/0", seen_valid, t_count, t_p);
    end
    checks++; if (t_ready_o !== 1'b1) begin errors++; $display("FAIL timeout_idle: ready=%b want 1", t_ready_o); end
    // Flag stays set through a later, finishing operation
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    t_finish = 1'b1;
    @(negedge clk);
    t_finish = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (t_timeout !== 1'b1 || t_count !== 16'd1) begin errors++; $display("FAIL timeout_sticky: timeout=%b count=%0d want 1/1", t_timeout, t_count); end
    t_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [WO-1:0] e;
    logic [WI-1:0] big;
    logic [WO-1:0] want;
    do_reset();
    mult_lat = 4;
    d_ready = 1'b1;
    issue(WI'(7), WI'(9));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++; if (d_en !== 1'b0 || d_ready_o !== 1'b1 || d_valid_o !== 1'b0 || d_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset: en=%b ready=%b valid=%b count=%0d want 0/1/0/0", d_en, d_ready_o, d_valid_o, d_count);
    end
    big = '0;
    big[WI-1] = 1'b1;
    want = '0;
    want[WI] = 1'b1;
    issue(big, WI'(2));
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_valid_timeout: o_valid never rose"); end
    e = exp_q.pop_front();
    checks++; if (d_p !== want || d_p !== e) begin errors++; $display("FAIL mid_big_oP: popcount=%0d bit1024=%b want 1/1", $countones(d_p), d_p[WI]); end
    @(negedge clk);
    checks++; if (d_count !== 16'd1) begin errors++; $display("FAIL mid_count: got %0d want 1", d_count); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, pops;
    logic [WO-1:0] e;
    do_reset();
    mult_lat = 4;
    d_ready = 1'b1;
    t0 = cyc;
    issue(WI'(6), WI'(7));
    t1 = -1;
    pops = 0;
    for (int i = 0; i < 40 && pops < 2; i++) begin
      if (d_valid_o) begin
        e = exp_q.pop_front();
        checks++; if (d_p !== e) begin errors++; $display("FAIL b2b_oP[%0d]: got %0d want %0d", pops, d_p[63:0], e[63:0]); end
        pops++;
      end
      if (d_ready_o && t1 < 0) begin
        t1 = cyc;
        issue(WI'(100), WI'(200));
      end else begin
        @(negedge clk);
      end
    end
    checks++; if (pops != 2 || t1 < 0) begin errors++; $display("FAIL b2b_done: pops=%0d want 2", pops); end
    checks++; if (t1 - t0 > mult_lat + 3) begin errors++; $display("FAIL b2b_period: got %0d want <= %0d", t1 - t0, mult_lat + 3); end
  endtask

  task automatic test_random();
    bit ok;
    logic [WO-1:0] e;
    int bad;
    do_reset();
    d_ready = 1'b0;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      for (int w = 0; w < 10 && !d_ready_o; w++) @(negedge clk);
      checks++; if (d_ready_o !== 1'b1) begin errors++; $display("FAIL rand_ready[%0d]: o_ready stuck low", n); end
      mult_lat = $urandom_range(1, 8);
      issue(rand_wide(), rand_wide());
      wait_valid(30, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_valid_timeout[%0d]: o_valid never rose", n); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (d_p !== e) begin errors++; $display("FAIL rand_oP[%0d]: low64 got %h want %h", n, d_p[63:0], e[63:0]); end
      checks++; if (d_last_lat !== 16'(mult_lat)) begin errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, d_last_lat, mult_lat); end
      d_ready = 1'b1;
      @(negedge clk);
      d_ready = 1'b0;
    end
    checks++; if (d_count !== 16'd100 || exp_q.size() != 0) begin errors++; $display("FAIL rand_count: count=%0d left=%0d want 100/0", d_count, exp_q.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    en_cnt = 0;
    mult_lat = 4;
    rst = 1'b1;
    d_valid = 1'b0;
    d_ready = 1'b1;
    d_a = '0;
    d_b = '0;
    t_valid = 1'b0;
    t_ready = 1'b0;
    t_a = '0;
    t_b = '0;
    t_finish = 1'b0;
    inject_finish = 1'b0;
    inject_val = '0;
    test_reset();
    test_basic();
    test_stall();
    test_idle_finish();
    test_finish_vs_timeout();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/karat_mult_driver.md
KARAT_MULT_DRIVER -- requirements
Module: karat_mult_driver

Interface
REQ-001 Parameter wI, default 1024, operand width in bits.
REQ-002 Parameter wO, default 2*wI, product width in bits.
REQ-003 Parameter TIMEOUT, default 4096, max cycles to wait for multiplier finish.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_valid  input  1  upstream operand pair valid.
REQ-007 o_ready  output  1  driver can accept an operand pair.
REQ-008 iA, iB  input  wI each  upstream operands.
REQ-009 o_valid  output  1  product available downstream.
REQ-010 i_ready  input  1  downstream accepts product.
REQ-011 oP  output  wO  captured product.
REQ-012 o_mult_enable  output  1  enable to multiplier.
REQ-013 o_mult_x, o_mult_y  output  wI each  operands to multiplier.
REQ-014 i_mult_finish  input  1  multiplier finish pulse.
REQ-015 i_mult_o  input  wO  multiplier product.
REQ-016 o_timeout  output  1  sticky timeout flag.
REQ-017 o_count  output  16  completed-transfer counter.
REQ-018 o_last_lat  output  16  enable-to-finish latency of last completed op.

Function
REQ-019 FSM states IDLE, BUSY, HOLD; reset state IDLE.
REQ-020 o_ready SHALL be 1 only in IDLE.
REQ-021 IDLE, i_valid=1: latch iA/iB into o_mult_x/o_mult_y, clear latency counter, go BUSY next cycle.
REQ-022 o_mult_enable SHALL be 1 exactly while in BUSY; o_mult_x/o_mult_y SHALL stay stable throughout BUSY.
REQ-023 BUSY, i_mult_finish=1: capture i_mult_o into oP, write latency count+1 to o_last_lat, go HOLD.
REQ-024 Latency counter SHALL increment each BUSY cycle without finish, saturating at 16'hFFFF.
REQ-025 BUSY, counter reaches TIMEOUT-1 without finish: set o_timeout, discard operation, go IDLE; oP unchanged.
REQ-026 Finish and timeout in the same cycle: finish wins, o_timeout unchanged.
REQ-027 o_valid SHALL be 1 exactly while in HOLD; oP SHALL stay stable in HOLD.
REQ-028 HOLD, i_ready=1: transfer completes, o_count increments (wraps 16'hFFFF->0), go IDLE.
REQ-029 i_mult_finish in IDLE or HOLD SHALL be ignored.
REQ-030 Back-to-back throughput: one operation per (multiplier latency + 3) cycles minimum.
REQ-031 o_timeout SHALL clear only on rst.

Reset
REQ-032 rst=1 at a clock edge: state IDLE; o_valid, o_mult_enable, o_timeout = 0; o_ready = 1 after reset.
REQ-033 rst=1 at a clock edge: oP, o_mult_x, o_mult_y, o_count, o_last_lat and the latency counter = 0.
REQ-034 Reset mid-operation (BUSY or HOLD) SHALL abandon the operation with no transfer and no count increment.

Verification
REQ-035 Model multiplier finishes 4 cycles after enable; drive iA=3, iB=5, i_ready=1 -> oP=15, o_valid for 1 cycle, o_last_lat=4, o_count=1.
REQ-036 Same op with i_ready=0 for 10 cycles -> o_valid and oP=15 held, o_ready=0; i_ready=1 -> IDLE next cycle, o_count=1.
REQ-037 TIMEOUT=16, model never finishes -> o_mult_enable drops after 16 BUSY cycles, o_timeout=1, o_valid never 1, o_count=0.
REQ-038 Finish pulse injected while IDLE with i_mult_o=all ones -> oP remains 0, o_valid=0.
REQ-039 rst asserted on 2nd BUSY cycle -> next cycle IDLE, o_mult_enable=0, o_count=0; a following op A=2^1023, B=2 completes with oP=2^1024.
REQ-040 100 random operand pairs with random i_ready stalls, checked against the behavioural product -> all match, o_count=100.
